// File: rtl/mmm_nlp_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for R = M^E mod N.
// It drives one external modular multiplier through a req/ack handshake.
module mmm_nlp_modexp_ctrl #(
  parameter int DW = 256,
  parameter int EW = 256,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_m,
  input  logic [EW-1:0] i_e,
  input  logic [DW-1:0] i_n,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_result,
  output logic [CW-1:0] o_nops,
  output logic          o_mul_req,
  output logic [DW-1:0] o_mul_a,
  output logic [DW-1:0] o_mul_b,
  output logic [DW-1:0] o_mul_n,
  input  logic          i_mul_ack,
  input  logic [DW-1:0] i_mul_res
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_MUL  = 3'd2,
    S_SQR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [EW-1:0] r_e;
  logic [DW-1:0] r_c, r_s, r_n;
  logic          r_mdone;
  logic          r_busy, r_done, r_err, r_req;
  logic [DW-1:0] r_result, r_a, r_b;
  logic [CW-1:0] r_nops;

  logic          w_ack;
  logic          w_do_mul;
  logic          w_finish;
  logic [CW-1:0] w_nops_inc;

  // An ack only counts while a request is outstanding.
  assign w_ack      = i_mul_ack & r_req;
  assign w_do_mul   = r_e[0] & ~r_mdone;
  assign w_finish   = (r_e == '0) | (~w_do_mul & (r_e[EW-1:1] == '0));
  assign w_nops_inc = (&r_nops) ? r_nops : r_nops + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_e      <= '0;
      r_c      <= '0;
      r_s      <= '0;
      r_n      <= '0;
      r_mdone  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_req    <= 1'b0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_nops   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_e     <= i_e;
            r_s     <= i_m;
            r_n     <= i_n;
            r_c     <= ONE;
            r_mdone <= 1'b0;
            r_nops  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            if (i_n == '0) begin
              r_state  <= S_DONE;
              r_result <= '0;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          // The trailing square is skipped once no exponent bits remain above bit 0.
          if (w_finish) begin
            r_state  <= S_DONE;
            r_result <= r_c;
            r_done   <= 1'b1;
          end else if (w_do_mul) begin
            r_state <= S_MUL;
            r_req   <= 1'b1;
            r_a     <= r_c;
            r_b     <= r_s;
          end else begin
            r_state <= S_SQR;
            r_req   <= 1'b1;
            r_a     <= r_s;
            r_b     <= r_s;
          end
        end
        S_MUL: begin
          if (w_ack) begin
            r_c     <= i_mul_res;
            r_mdone <= 1'b1;
            r_nops  <= w_nops_inc;
            r_req   <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        S_SQR: begin
          if (w_ack) begin
            r_s     <= i_mul_res;
            r_e     <= r_e >> 1;
            r_mdone <= 1'b0;
            r_nops  <= w_nops_inc;
            r_req   <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_result  = r_result;
  assign o_nops    = r_nops;
  assign o_mul_req = r_req;
  assign o_mul_a   = r_a;
  assign o_mul_b   = r_b;
  assign o_mul_n   = r_n;

endmodule
